// File: rtl/spi_main_if.sv
// Host-side request/response signals and the SPI link to the sub-node, bundled for spi_main.
// The master modport is the controller's view; slave is the view of whatever drives it.
interface spi_main_if #(
  parameter int unsigned DATA_W = 128
) ();
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              done;
  logic              cs;
  logic              sclk;
  logic              mosi;
  logic              miso;

  modport master (
    input  start, tx_data, miso,
    output rx_data, busy, done, cs, sclk, mosi
  );

  modport slave (
    output start, tx_data, miso,
    input  rx_data, busy, done, cs, sclk, mosi
  );
endinterface

// File: rtl/spi_main.sv
// SPI controller: sends one DATA_W-bit block MSB-first on mosi while capturing miso, then pulses
// done with the received block. A trailing sclk pulse with cs high resets the sub's bit counter.
module spi_main #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  spi_main_if.master bus
);
  localparam int unsigned       CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [7:0]        DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(DATA_W);

  typedef enum logic [2:0] {
    StIdle, StSetup, StShiftHi, StShiftLo, StHold, StFlushHi, StFlushLo, StFin
  } state_e;

  state_e            state_q;
  logic [7:0]        div_q;
  logic [CNT_W-1:0]  bit_q;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              cs_q;
  logic              sclk_q;
  logic              mosi_q;
  logic              busy_q;
  logic              done_q;
  logic              phase_end;

  assign phase_end   = (div_q == DIV_LAST);
  assign bus.rx_data = rx_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.cs      = cs_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      div_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Every timed phase lasts exactly CLK_DIV cycles.
      if (state_q inside {StIdle, StFin} || phase_end) begin
        div_q <= '0;
      end else begin
        div_q <= div_q + 8'd1;
      end

      unique case (state_q)
        StIdle: begin
          cs_q   <= 1'b1;
          sclk_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
            tx_q    <= bus.tx_data;
            mosi_q  <= bus.tx_data[DATA_W-1];
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            bit_q   <= '0;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (phase_end) begin
            sclk_q  <= 1'b1;
            state_q <= StShiftHi;
          end
        end
        StShiftHi: begin
          if (phase_end) begin
            sclk_q  <= 1'b0;
            rx_q    <= {rx_q[DATA_W-2:0], bus.miso};
            bit_q   <= bit_q + CNT_W'(1);
            state_q <= StShiftLo;
          end
        end
        StShiftLo: begin
          if (phase_end) begin
            if (bit_q == BIT_LAST) begin
              mosi_q  <= 1'b0;
              state_q <= StHold;
            end else begin
              tx_q    <= {tx_q[DATA_W-2:0], 1'b0};
              mosi_q  <= tx_q[DATA_W-2];
              sclk_q  <= 1'b1;
              state_q <= StShiftHi;
            end
          end
        end
        StHold: begin
          if (phase_end) begin
            cs_q    <= 1'b1;
            sclk_q  <= 1'b1;
            state_q <= StFlushHi;
          end
        end
        StFlushHi: begin
          if (phase_end) begin
            sclk_q  <= 1'b0;
            state_q <= StFlushLo;
          end
        end
        StFlushLo: begin
          if (phase_end) begin
            rx_data_q <= rx_q;
            done_q    <= 1'b1;
            state_q   <= StFin;
          end
        end
        StFin: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_main.sv
// Bench for spi_main: directed and random frames against a behavioural SPI sub model and loopback,
// with edge counting, latency and reset checks.
module tb_spi_main;
  localparam int unsigned DW  = 128;
  localparam int unsigned D   = 4;
  localparam int          LAT = (2 * DW + 4) * D;  // accept edge to the edge that raises done

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  bit   loop  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  spi_main_if #(.DATA_W(DW)) bus ();

  spi_main #(.DATA_W(DW), .CLK_DIV(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Sub-node model: presents sdo MSB-first (updated on rising sclk), samples sdi on falling
  // sclk, raises done after DW bits, clears its counter on any sclk edge seen with cs high.
  logic [DW-1:0] sub_tx = '0;
  logic [DW-1:0] sub_rx = '0;
  logic          sub_sdo = 1'b0;
  logic          sub_done = 1'b0;
  int            sub_cnt = 0;
  logic          cs_prev = 1'b1;
  logic          sclk_prev = 1'b0;

  always @(bus.sclk or bus.cs) begin
    if (bus.cs !== cs_prev && bus.cs === 1'b0) begin
      sub_sdo  = sub_tx[DW-1];
      sub_done = 1'b0;
    end else if (bus.sclk !== sclk_prev) begin
      if (bus.cs) begin
        sub_cnt = 0;
      end else if (bus.sclk) begin
        if (sub_cnt < DW) sub_sdo = sub_tx[DW-1-sub_cnt];
      end else begin
        sub_rx = {sub_rx[DW-2:0], bus.mosi};
        sub_cnt++;
        if (sub_cnt == DW) sub_done = 1'b1;
      end
    end
    cs_prev   = bus.cs;
    sclk_prev = bus.sclk;
  end

  assign bus.miso = loop ? bus.mosi : sub_sdo;

  function automatic logic [DW-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Caller sits on the first negedge after the accepting edge; returns cycles until done.
  task automatic wait_done(output int done_k);
    done_k = -1;
    for (int k = 0; k < LAT + 100; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.done) begin
        done_k = k;
        break;
      end
    end
  endtask

  task automatic do_frame(input string tag, input logic [DW-1:0] tx, input logic [DW-1:0] stx,
                          input bit lb, input bit disturb);
    int falls;
    int first_rise;
    int done_k;
    bit prev_sclk;
    falls = 0; first_rise = -1; done_k = -1; prev_sclk = 1'b0;
    loop = lb;
    sub_tx = stx;
    @(negedge clk);
    bus.tx_data = tx;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, " busy"}, DW'(bus.busy), DW'(1));
    check({tag, " cs"}, DW'(bus.cs), DW'(0));
    for (int k = 0; k < LAT + 100; k++) begin
      if (k > 0) @(negedge clk);
      if (disturb) begin
        if (k == 5) begin
          bus.start   = 1'b1;
          bus.tx_data = rand128();
        end
        if (k == 8) bus.start = 1'b0;
        if (k == 300) bus.tx_data = ~tx;
      end
      if (bus.sclk && !prev_sclk && first_rise < 0) first_rise = k;
      if (!bus.sclk && prev_sclk && !bus.cs) falls++;
      prev_sclk = bus.sclk;
      if (bus.done) begin
        done_k = k;
        break;
      end
    end
    check({tag, " latency"}, DW'(done_k), DW'(LAT));
    check({tag, " falls"}, DW'(falls), DW'(DW));
    check({tag, " first rise"}, DW'(first_rise), DW'(D));
    check({tag, " rx_data"}, bus.rx_data, lb ? tx : stx);
    check({tag, " busy at done"}, DW'(bus.busy), DW'(1));
    if (!lb) begin
      check({tag, " sub rx"}, sub_rx, tx);
      check({tag, " sub done"}, DW'(sub_done), DW'(1));
      check({tag, " sub flushed"}, DW'(sub_cnt), DW'(0));
    end
    @(negedge clk);
    check({tag, " done pulse"}, DW'(bus.done), DW'(0));
    check({tag, " busy after"}, DW'(bus.busy), DW'(0));
    check({tag, " cs idle"}, DW'(bus.cs), DW'(1));
  endtask

  initial begin
    int k;
    logic [DW-1:0] a_word;
    logic [DW-1:0] b_word;
    bus.start   = 1'b0;
    bus.tx_data = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset cs", DW'(bus.cs), DW'(1));
    check("reset sclk", DW'(bus.sclk), DW'(0));
    check("reset mosi", DW'(bus.mosi), DW'(0));
    check("reset busy", DW'(bus.busy), DW'(0));
    check("reset done", DW'(bus.done), DW'(0));
    check("reset rx_data", bus.rx_data, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle cs", DW'(bus.cs), DW'(1));

    do_frame("loopback", 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, '0, 1'b1, 1'b0);
    do_frame("sub", {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, {16{8'hA5}}, 1'b0, 1'b0);
    do_frame("disturb", rand128(), rand128(), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      do_frame($sformatf("rand%0d", i), rand128(), rand128(), i[0], 1'b0);
    end

    // Back-to-back: start stays high across the done cycle.
    a_word = rand128();
    b_word = rand128();
    loop = 1'b0;
    sub_tx = a_word;
    @(negedge clk);
    bus.tx_data = 128'h1;
    bus.start   = 1'b1;
    @(negedge clk);
    wait_done(k);
    check("b2b first latency", DW'(k), DW'(LAT));
    check("b2b first rx", bus.rx_data, a_word);
    check("b2b first sub rx", sub_rx, 128'h1);
    bus.tx_data = {1'b1, 127'b0};
    sub_tx = b_word;
    @(negedge clk);
    check("b2b gap busy", DW'(bus.busy), DW'(0));
    @(negedge clk);
    check("b2b restart busy", DW'(bus.busy), DW'(1));
    check("b2b restart cs", DW'(bus.cs), DW'(0));
    bus.start = 1'b0;
    wait_done(k);
    check("b2b second latency", DW'(k), DW'(LAT));
    check("b2b second rx", bus.rx_data, b_word);
    check("b2b second sub rx", sub_rx, {1'b1, 127'b0});
    check("b2b sub flushed", DW'(sub_cnt), DW'(0));
    @(negedge clk);
    @(negedge clk);

    // Reset in mid-shift must act at once and leave rx_data cleared.
    loop = 1'b1;
    bus.tx_data = rand128();
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (300) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort cs", DW'(bus.cs), DW'(1));
    check("abort sclk", DW'(bus.sclk), DW'(0));
    check("abort busy", DW'(bus.busy), DW'(0));
    check("abort done", DW'(bus.done), DW'(0));
    check("abort rx_data", bus.rx_data, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 20) @(negedge clk);
    check("post abort rx_data", bus.rx_data, '0);
    check("post abort busy", DW'(bus.busy), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
